// File: rtl/beta_trap_ctrl_pkg.sv
// Shared encodings for the Beta trap controller: PCSEL values, trap vectors, XP index,
// CAUSE codes and the trap FSM state type.
package beta_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        PcselPc4   = 3'd0,
        PcselBr    = 3'd1,
        PcselJt    = 3'd2,
        PcselIllop = 3'd3,
        PcselIrq   = 3'd4
    } pcsel_e;

    localparam logic [31:0] IllopVector = 32'h8000_0004;
    localparam logic [31:0] IrqVector   = 32'h8000_0008;

    // XP register that receives PC+4 when WASEL selects it
    localparam logic [4:0] XpIdx = 5'd30;

    localparam logic [2:0] CauseNone    = 3'd0;
    localparam logic [2:0] CauseIllop   = 3'd1;
    localparam logic [2:0] CauseIrqBase = 3'd2;

    typedef enum logic {
        StRun     = 1'b0,
        StTrapped = 1'b1
    } trap_state_e;

    function automatic logic [2:0] irq_cause(input logic [2:0] idx);
        return CauseIrqBase + idx;
    endfunction

endpackage

// File: rtl/beta_irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, followed by a rising-edge
// detector on the synchronised level.
module beta_irq_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    output logic rise_o
);

    logic [Stages-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[Stages-2:0], irq_i};
        prev_d = sync_q[Stages-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/beta_trap_ctrl.sv
// Trap/interrupt controller for the unpipelined Beta: latches synchronised IRQ edges,
// arbitrates them against illegal opcodes and overrides the decoder's selects on a take.
module beta_trap_ctrl
    import beta_trap_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [IRQ_W-1:0] IRQ,
    input  logic [IRQ_W-1:0] IRQ_MASK,
    input  logic             INST_VALID,
    input  logic             ILLOP,
    input  logic             PC_SUPER,
    input  logic [2:0]       DEC_PCSEL,
    input  logic             DEC_WASEL,
    input  logic [1:0]       DEC_WDSEL,
    input  logic             DEC_WERF,
    input  logic             DEC_MWR,
    output logic [2:0]       PCSEL,
    output logic             WASEL,
    output logic [1:0]       WDSEL,
    output logic             WERF,
    output logic             MWR,
    output logic [IRQ_W-1:0] IACK,
    output logic [2:0]       CAUSE,
    output logic             IN_HANDLER,
    output logic             DOUBLE_FAULT
);

    logic [IRQ_W-1:0] irq_rise;
    logic [IRQ_W-1:0] pend_q, pend_d;
    logic [IRQ_W-1:0] iack_q, iack_d;
    logic [2:0]       cause_q, cause_d;
    logic             df_q, df_d;
    trap_state_e      state_q, state_d;

    logic [IRQ_W-1:0] masked;
    logic [IRQ_W-1:0] winner;
    logic [2:0]       win_idx;
    logic             illop_take;
    logic             irq_take;
    logic             take;

    for (genvar g = 0; g < IRQ_W; g++) begin : g_sync
        beta_irq_sync #(
            .Stages (SYNC_STAGES)
        ) u_sync (
            .clk_i  (CLK),
            .rst_ni (RESET_N),
            .irq_i  (IRQ[g]),
            .rise_o (irq_rise[g])
        );
    end

    // Arbitration: illop ignores mode and mask; irqs only in user mode, lowest index wins.
    always_comb begin
        masked  = pend_q & ~IRQ_MASK;
        winner  = '0;
        win_idx = '0;
        for (int k = int'(IRQ_W) - 1; k >= 0; k--) begin
            if (masked[k]) begin
                winner    = '0;
                winner[k] = 1'b1;
                win_idx   = 3'(k);
            end
        end
        illop_take = INST_VALID & ILLOP;
        irq_take   = INST_VALID & ~ILLOP & ~PC_SUPER & (|masked);
        take       = illop_take | irq_take;
    end

    // A take squashes the instruction: PC+4 goes to XP and any store is dropped.
    always_comb begin
        PCSEL = DEC_PCSEL;
        WASEL = DEC_WASEL;
        WDSEL = DEC_WDSEL;
        WERF  = DEC_WERF;
        MWR   = DEC_MWR;
        if (take) begin
            PCSEL = illop_take ? PcselIllop : PcselIrq;
            WASEL = 1'b1;
            WDSEL = 2'b00;
            WERF  = 1'b1;
            MWR   = 1'b0;
        end
    end

    always_comb begin
        iack_d  = irq_take ? winner : '0;
        // Clear only the acknowledged line; a fresh edge in the same cycle re-arms it.
        pend_d  = (pend_q & ~iack_d) | irq_rise;
        cause_d = cause_q;
        if (illop_take) begin
            cause_d = CauseIllop;
        end else if (irq_take) begin
            cause_d = irq_cause(win_idx);
        end
        df_d    = df_q | (illop_take & (state_q == StTrapped));
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (take) state_d = StTrapped;
            end
            StTrapped: begin
                if (!take && INST_VALID && !PC_SUPER) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q  <= '0;
            iack_q  <= '0;
            cause_q <= CauseNone;
            df_q    <= 1'b0;
            state_q <= StRun;
        end else begin
            pend_q  <= pend_d;
            iack_q  <= iack_d;
            cause_q <= cause_d;
            df_q    <= df_d;
            state_q <= state_d;
        end
    end

    assign IACK         = iack_q;
    assign CAUSE        = cause_q;
    assign IN_HANDLER   = (state_q == StTrapped);
    assign DOUBLE_FAULT = df_q;

endmodule

// File: tb/tb_beta_trap_ctrl.sv
// Self-checking bench for beta_trap_ctrl: directed scenarios plus a randomized run against
// a cycle-level behavioural model of pending interrupts, cause and handler state.
module tb_beta_trap_ctrl;

    localparam int IRQ_W = 4;
    localparam int SYNC  = 2;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [IRQ_W-1:0] IRQ, IRQ_MASK;
    logic             INST_VALID, ILLOP, PC_SUPER;
    logic [2:0]       DEC_PCSEL;
    logic             DEC_WASEL;
    logic [1:0]       DEC_WDSEL;
    logic             DEC_WERF, DEC_MWR;
    logic [2:0]       PCSEL;
    logic             WASEL;
    logic [1:0]       WDSEL;
    logic             WERF, MWR;
    logic [IRQ_W-1:0] IACK;
    logic [2:0]       CAUSE;
    logic             IN_HANDLER, DOUBLE_FAULT;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [IRQ_W-1:0] m_pend, m_iack;
    logic [2:0]       m_cause;
    logic             m_inh, m_df;
    logic [IRQ_W-1:0] m_hist[$];

    beta_trap_ctrl #(
        .IRQ_W       (IRQ_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .IRQ          (IRQ),
        .IRQ_MASK     (IRQ_MASK),
        .INST_VALID   (INST_VALID),
        .ILLOP        (ILLOP),
        .PC_SUPER     (PC_SUPER),
        .DEC_PCSEL    (DEC_PCSEL),
        .DEC_WASEL    (DEC_WASEL),
        .DEC_WDSEL    (DEC_WDSEL),
        .DEC_WERF     (DEC_WERF),
        .DEC_MWR      (DEC_MWR),
        .PCSEL        (PCSEL),
        .WASEL        (WASEL),
        .WDSEL        (WDSEL),
        .WERF         (WERF),
        .MWR          (MWR),
        .IACK         (IACK),
        .CAUSE        (CAUSE),
        .IN_HANDLER   (IN_HANDLER),
        .DOUBLE_FAULT (DOUBLE_FAULT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dec_vec();
        return {DEC_PCSEL, DEC_WASEL, DEC_WDSEL, DEC_WERF, DEC_MWR};
    endfunction

    function automatic logic [7:0] act_vec();
        return {PCSEL, WASEL, WDSEL, WERF, MWR};
    endfunction

    // Expected final selects from the current inputs and the model's pending set.
    function automatic logic [7:0] exp_vec();
        logic [IRQ_W-1:0] avail;
        avail = m_pend & ~IRQ_MASK;
        if (INST_VALID && ILLOP) return {3'd3, 1'b1, 2'b00, 1'b1, 1'b0};
        if (INST_VALID && !PC_SUPER && avail != 0) return {3'd4, 1'b1, 2'b00, 1'b1, 1'b0};
        return dec_vec();
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_iack  = '0;
        m_cause = 3'd0;
        m_inh   = 1'b0;
        m_df    = 1'b0;
        m_hist.delete();
        for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
    endtask

    // Advance one clock: predict the edge's effects, then stop at the next falling edge.
    task automatic tick();
        logic [IRQ_W-1:0] avail, rise, ack;
        logic             il, ir;
        int               win;
        avail = m_pend & ~IRQ_MASK;
        il    = INST_VALID && ILLOP;
        ir    = INST_VALID && !ILLOP && !PC_SUPER && avail != 0;
        win   = -1;
        for (int k = 0; k < IRQ_W; k++) if (avail[k] && win < 0) win = k;
        // Synchronised level lags the raw samples by SYNC edges; pend sets on its 0->1 step.
        rise  = m_hist[SYNC-1] & ~m_hist[SYNC];
        @(posedge CLK);
        if (RESET_N) begin
            ack     = ir ? (IRQ_W'(1) << win) : '0;
            m_pend  = (m_pend & ~ack) | rise;
            m_iack  = ack;
            if (il) m_cause = 3'd1;
            else if (ir) m_cause = 3'(2 + win);
            if (il && m_inh) m_df = 1'b1;
            if (il || ir) m_inh = 1'b1;
            else if (INST_VALID && !PC_SUPER) m_inh = 1'b0;
            m_hist.push_front(IRQ);
            void'(m_hist.pop_back());
        end
        @(negedge CLK);
    endtask

    task automatic set_dec();
        DEC_PCSEL = 3'($urandom_range(0, 2));
        DEC_WASEL = 1'b0;
        DEC_WDSEL = 2'($urandom_range(1, 2));
        DEC_WERF  = 1'($urandom_range(0, 1));
        DEC_MWR   = 1'b1;
    endtask

    task automatic idle_inputs();
        IRQ        = '0;
        IRQ_MASK   = '0;
        INST_VALID = 1'b0;
        ILLOP      = 1'b0;
        PC_SUPER   = 1'b0;
        set_dec();
    endtask

    task automatic apply_reset();
        idle_inputs();
        RESET_N = 1'b0;
        model_reset();
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        int first_take;
        idle_inputs();
        IRQ     = 4'hF;
        RESET_N = 1'b0;
        model_reset();
        repeat (3) tick();
        #1;
        n_checks++;
        if (IACK !== 4'h0 || CAUSE !== 3'd0 || IN_HANDLER !== 1'b0 || DOUBLE_FAULT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: iack=%h cause=%0d inh=%b df=%b, want 0 0 0 0",
                     IACK, CAUSE, IN_HANDLER, DOUBLE_FAULT);
        end
        n_checks++;
        if (act_vec() !== dec_vec()) begin
            n_fail++;
            $display("FAIL reset_passthru: got %h want %h", act_vec(), dec_vec());
        end
        @(negedge CLK);
        RESET_N    = 1'b1;
        INST_VALID = 1'b1;
        first_take = -1;
        for (int c = 0; c < 6; c++) begin
            set_dec();
            #1;
            if (PCSEL === 3'd4 && first_take < 0) first_take = c;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_release_c%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            tick();
        end
        n_checks++;
        if (first_take != SYNC + 1) begin
            n_fail++;
            $display("FAIL irq_latency: first take at cycle %0d, want %0d", first_take, SYNC + 1);
        end
    endtask

    task automatic test_illop();
        apply_reset();
        set_dec();
        INST_VALID = 1'b1;
        ILLOP      = 1'b1;
        PC_SUPER   = 1'b0;
        DEC_MWR    = 1'b1;
        #1;
        n_checks++;
        if (act_vec() !== {3'd3, 1'b1, 2'b00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL illop_override: got %h want %h", act_vec(), {3'd3, 1'b1, 2'b00, 2'b10});
        end
        tick();
        n_checks++;
        if (CAUSE !== 3'd1 || IN_HANDLER !== 1'b1 || IACK !== 4'h0) begin
            n_fail++;
            $display("FAIL illop_status: cause=%0d inh=%b iack=%h, want 1 1 0",
                     CAUSE, IN_HANDLER, IACK);
        end
    endtask

    task automatic test_irq_mask();
        apply_reset();
        IRQ_MASK = 4'b0010;
        IRQ      = 4'b0110;
        tick();
        IRQ = 4'b0000;
        repeat (SYNC + 1) tick();
        set_dec();
        INST_VALID = 1'b1;
        #1;
        n_checks++;
        if (PCSEL !== 3'd4) begin
            n_fail++;
            $display("FAIL irq_take_pcsel: got %0d want 4", PCSEL);
        end
        tick();
        n_checks++;
        if (IACK !== 4'b0100 || CAUSE !== 3'd4 || IN_HANDLER !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_line2: iack=%b cause=%0d inh=%b, want 0100 4 1",
                     IACK, CAUSE, IN_HANDLER);
        end
        PC_SUPER = 1'b1;
        tick();
        n_checks++;
        if (IACK !== 4'b0000) begin
            n_fail++;
            $display("FAIL iack_pulse_width: got %b want 0000", IACK);
        end
        PC_SUPER = 1'b0;
        set_dec();
        #1;
        n_checks++;
        if (act_vec() !== dec_vec()) begin
            n_fail++;
            $display("FAIL masked_line_held: got %h want %h", act_vec(), dec_vec());
        end
        tick();
        IRQ_MASK = 4'b0000;
        #1;
        n_checks++;
        if (PCSEL !== 3'd4) begin
            n_fail++;
            $display("FAIL unmasked_take: got %0d want 4", PCSEL);
        end
        tick();
        n_checks++;
        if (IACK !== 4'b0010 || CAUSE !== 3'd3) begin
            n_fail++;
            $display("FAIL irq_line1: iack=%b cause=%0d, want 0010 3", IACK, CAUSE);
        end
    endtask

    task automatic test_super_block();
        int bad;
        apply_reset();
        IRQ = 4'b0001;
        tick();
        IRQ = 4'b0000;
        repeat (SYNC + 1) tick();
        INST_VALID = 1'b1;
        PC_SUPER   = 1'b1;
        bad        = 0;
        for (int c = 0; c < 10; c++) begin
            set_dec();
            #1;
            if (act_vec() !== dec_vec() || IACK !== 4'h0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL super_block: %0d cycles overridden, want 0", bad);
        end
        PC_SUPER = 1'b0;
        #1;
        n_checks++;
        if (PCSEL !== 3'd4) begin
            n_fail++;
            $display("FAIL user_take: got %0d want 4", PCSEL);
        end
        tick();
        n_checks++;
        if (IN_HANDLER !== 1'b1 || IACK !== 4'b0001 || CAUSE !== 3'd2) begin
            n_fail++;
            $display("FAIL user_take_status: inh=%b iack=%b cause=%0d, want 1 0001 2",
                     IN_HANDLER, IACK, CAUSE);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        IRQ = 4'b1000;
        tick();
        IRQ = 4'b0000;
        repeat (SYNC + 1) tick();
        INST_VALID = 1'b1;
        ILLOP      = 1'b1;
        #1;
        n_checks++;
        if (PCSEL !== 3'd3) begin
            n_fail++;
            $display("FAIL simul_pcsel: got %0d want 3", PCSEL);
        end
        tick();
        n_checks++;
        if (CAUSE !== 3'd1 || IACK !== 4'h0) begin
            n_fail++;
            $display("FAIL simul_cause: cause=%0d iack=%b, want 1 0000", CAUSE, IACK);
        end
        ILLOP = 1'b0;
        #1;
        n_checks++;
        if (PCSEL !== 3'd4) begin
            n_fail++;
            $display("FAIL simul_irq_later: got %0d want 4", PCSEL);
        end
        tick();
        n_checks++;
        if (CAUSE !== 3'd5 || IACK !== 4'b1000 || IN_HANDLER !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_irq_status: cause=%0d iack=%b inh=%b, want 5 1000 1",
                     CAUSE, IACK, IN_HANDLER);
        end
    endtask

    task automatic test_double_fault();
        apply_reset();
        INST_VALID = 1'b1;
        ILLOP      = 1'b1;
        tick();
        PC_SUPER = 1'b1;
        #1;
        n_checks++;
        if (PCSEL !== 3'd3) begin
            n_fail++;
            $display("FAIL df_vectors: got %0d want 3", PCSEL);
        end
        tick();
        n_checks++;
        if (DOUBLE_FAULT !== 1'b1 || IN_HANDLER !== 1'b1) begin
            n_fail++;
            $display("FAIL df_set: df=%b inh=%b, want 1 1", DOUBLE_FAULT, IN_HANDLER);
        end
        PC_SUPER = 1'b0;
        tick();
        ILLOP = 1'b0;
        tick();
        n_checks++;
        if (DOUBLE_FAULT !== 1'b1 || IN_HANDLER !== 1'b0) begin
            n_fail++;
            $display("FAIL df_sticky: df=%b inh=%b, want 1 0", DOUBLE_FAULT, IN_HANDLER);
        end
        ILLOP = 1'b1;
        tick();
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (DOUBLE_FAULT !== 1'b0 || IN_HANDLER !== 1'b0 || CAUSE !== 3'd0) begin
            n_fail++;
            $display("FAIL df_async_clear: df=%b inh=%b cause=%0d, want 0 0 0",
                     DOUBLE_FAULT, IN_HANDLER, CAUSE);
        end
        @(negedge CLK);
        idle_inputs();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_random();
        int bad_ctl, bad_state;
        apply_reset();
        bad_ctl   = 0;
        bad_state = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) IRQ[$urandom_range(0, IRQ_W - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) IRQ_MASK = 4'($urandom_range(0, 15));
            INST_VALID = ($urandom_range(0, 3) != 0);
            ILLOP      = ($urandom_range(0, 9) == 0);
            PC_SUPER   = ($urandom_range(0, 2) == 0);
            DEC_PCSEL  = 3'($urandom_range(0, 7));
            DEC_WASEL  = 1'($urandom_range(0, 1));
            DEC_WDSEL  = 2'($urandom_range(0, 3));
            DEC_WERF   = 1'($urandom_range(0, 1));
            DEC_MWR    = 1'($urandom_range(0, 1));
            #1;
            if (act_vec() !== exp_vec()) begin
                bad_ctl++;
                if (bad_ctl <= 3)
                    $display("FAIL rand_ctl_c%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            tick();
            if (IACK !== m_iack || CAUSE !== m_cause || IN_HANDLER !== m_inh ||
                DOUBLE_FAULT !== m_df) begin
                bad_state++;
                if (bad_state <= 3)
                    $display("FAIL rand_state_c%0d: iack=%b cause=%0d inh=%b df=%b, want %b %0d %b %b",
                             c, IACK, CAUSE, IN_HANDLER, DOUBLE_FAULT,
                             m_iack, m_cause, m_inh, m_df);
            end
        end
        n_checks++;
        if (bad_ctl != 0) n_fail++;
        n_checks++;
        if (bad_state != 0) n_fail++;
    endtask

    initial begin
        RESET_N = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge CLK);
        test_reset();
        test_illop();
        test_irq_mask();
        test_super_block();
        test_simultaneous();
        test_double_fault();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
